tx_frame_sequencer: RTL and testbench
=====================================

Name: tx_frame_sequencer

Overview:
- Frame-level scheduler in front of the transmit encoder/PCS state machine.
- Accepts a MAC byte stream (valid/ready/last/error) and produces the encoder-side controls: symbol timer strobe, symbol counter n, n0 snapshot, tx_enable/tx_error/txd, tx_mode.
- Enforces minimum inter-frame gap and maximum frame length.
- Throttles on encoder backpressure (tx_symb_vector_ready).

Parameters:
- SYMB_DIV, 1: clock cycles per symbol period (>=1).
- MIN_IFG, 12: idle symbol periods forced after each frame and after link-up.
- MAX_FRAME, 1522: maximum bytes per frame before forced abort.

Ports:
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- link_enable  in  1  management enable.
- loc_rcvr_status  in  1  local receiver OK.
- in_valid  in  1  MAC byte valid.
- in_data  in  8  MAC byte.
- in_last  in  1  last byte of frame.
- in_error  in  1  MAC-signalled error on this byte.
- in_ready  out  1  byte accepted this cycle.
- enc_ready  in  1  encoder ready (tx_symb_vector_ready).
- symb_timer_done  out  1  one-cycle symbol strobe.
- n  out  32  symbol counter.
- n0  out  32  n captured at link-up.
- tx_mode  out  1  1 = send normal, 0 = send zeros.
- tx_enable  out  1  to encoder.
- tx_error  out  1  to encoder.
- txd  out  8  to encoder.

Behaviour:
- Reset (async assert, sync release): state DISABLED, divider 0, all outputs 0 (n, n0, txd included).
- Divider:
  - Counts 0..SYMB_DIV-1 only while enc_ready=1; frozen while enc_ready=0.
  - tick = enc_ready && div==SYMB_DIV-1. symb_timer_done = tick, registered, so the pulse appears one cycle after the tick condition.
  - n increments by 1 on each tick and wraps 2^32-1 -> 0 (runs in all states except during reset).
- States: DISABLED, IFG, IDLE, DATA, DRAIN.
- DISABLED:
  - tx_mode=0, tx_enable=0, in_ready=0.
  - When link_enable && loc_rcvr_status: n0<=n, load gap counter=MIN_IFG, go IFG.
- IFG:
  - tx_mode=1, tx_enable=0, in_ready=0.
  - Gap counter decrements on each tick; on reaching 0, go IDLE.
  - MIN_IFG=0 means IDLE on the next cycle.
- IDLE:
  - in_ready = tick.
  - Tick with in_valid: accept byte, go DATA; byte count=1.
  - Tick without in_valid: stay.
- DATA, byte accepted on a tick with in_valid:
  - in_ready=1 on that tick; txd<=in_data, tx_enable<=1, tx_error<=in_error.
  - in_last=1: go IFG with gap=MIN_IFG.
  - Byte count reaching MAX_FRAME without in_last: tx_error<=1 for that symbol, go DRAIN.
- DATA, tick without in_valid (underrun):
  - tx_enable<=1, tx_error<=1, txd<=0 for one symbol, then go DRAIN.
- DRAIN:
  - tx_enable<=0; in_ready=in_valid, so bytes are discarded at clock rate regardless of tick.
  - On an accepted in_last: go IFG with gap=MIN_IFG.
- Output timing: txd/tx_enable/tx_error are registered, change only on cycle after a tick, and hold for the whole symbol period. Latency from in_ready&&in_valid to txd = 1 cycle.
- Link loss: link_enable=0 or loc_rcvr_status=0 in any state other than DISABLED → DISABLED on the next edge.
  - tx_enable, tx_error and tx_mode are cleared on that edge.
  - If a frame was open, a pending-drain flag is set. On link return the FSM enters DRAIN instead of IFG; DRAIN then ends in IFG, so a partial frame is never resent.
- Simultaneous link loss and tick: link loss wins; no byte accepted.
- Byte counter: 11 bits, saturating, cleared on every frame start.

Decomposition:
- Shared package tx_seq_pkg: state enum, default MIN_IFG/MAX_FRAME constants, GMII byte struct {data, last, error}.
- One sub-module is natural: symb_timer (divider, tick, n counter, n0 capture).
- FSM and datapath stay in the top.

Test Plan:
- Reset: assert reset=0 mid-frame → next sample shows all outputs 0, state DISABLED, n=0; release → n counts again with enc_ready=1.
- Bring-up with SYMB_DIV=1, MIN_IFG=12: raise link_enable/loc_rcvr_status when n=37 → n0=37; in_ready stays 0 for exactly 12 ticks, then IDLE.
- Frame of bytes 00,01,02,03 (last on 03), enc_ready=1 → tx_enable=1 for exactly 4 cycles with txd 00,01,02,03, then 0. Next frame's first in_ready no earlier than 12 cycles later.
- Backpressure: enc_ready=0 for 3 cycles after byte 01 → n, txd=01 and symb_timer_done (0) frozen, in_ready=0; resumes with 02 on release.
- Underrun: in_valid low on the tick after byte 01 → one symbol with tx_enable=1, tx_error=1, txd=00, then tx_enable=0; remaining bytes drained through last, then 12-tick IFG.
- Link loss mid-frame: loc_rcvr_status=0 after byte 02 → tx_enable=0, tx_mode=0 next cycle. On return, the rest of the frame is drained (no txd output), then IFG then IDLE.
- MAX_FRAME=4 with a 6-byte frame → byte 4 carries tx_error=1, bytes 5-6 drained.

Source files
------------

// File: rtl/tx_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : tx_seq_pkg                                                   |
// | Description : Shared types and defaults for the transmit frame sequencer:  |
// |               FSM state encoding, GMII byte bundle, byte-counter type and  |
// |               a saturating increment helper.                               |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package tx_seq_pkg;

  localparam int unsigned c_min_ifg_dflt   = 12;
  localparam int unsigned c_max_frame_dflt = 1522;

  // Sequencer states. The encoding is explicit so that state values are
  // stable across tool versions.
  typedef enum logic [2:0] {
    ST_DISABLED = 3'd0,
    ST_IFG      = 3'd1,
    ST_IDLE     = 3'd2,
    ST_DATA     = 3'd3,
    ST_DRAIN    = 3'd4
  } tx_state_e;

  // One MAC-side byte with its framing/error qualifiers.
  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       error;
  } gmii_byte_t;

  // Per-frame byte counter; wide enough for MAX_FRAME values up to 2047.
  typedef logic [10:0] byte_cnt_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic byte_cnt_t sat_inc(input byte_cnt_t v);
    return (&v) ? v : v + 11'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tx_frame_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface   : tx_frame_sequencer_if                                        |
// | Description : MAC byte-stream handshake into the frame sequencer.          |
// |   in_valid  MAC byte valid          in_data  MAC byte                      |
// |   in_last   last byte of frame      in_error MAC error on this byte        |
// |   in_ready  byte accepted this cycle (driven by the sequencer)             |
// |   master = MAC side, slave = sequencer side                                |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
interface tx_frame_sequencer_if;
  import tx_seq_pkg::*;

  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_error;
  logic       in_ready;

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    output in_error,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    input  in_error,
    output in_ready
  );

endinterface
`default_nettype wire

// File: rtl/tx_frame_sequencer_symb_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tx_frame_sequencer_symb_timer                                |
// | Description : Symbol timer. Divides the clock by SYMB_DIV while the        |
// |               encoder is ready, produces the tick, the registered symbol   |
// |               strobe, the free-running symbol counter n and the n0         |
// |               snapshot taken at link-up.                                   |
// |   clock, reset        clock / async active-low reset                       |
// |   enc_ready           encoder ready; divider frozen while low              |
// |   capture_n0          load n0 from n on this edge                          |
// |   tick                combinational: last divider cycle with enc_ready     |
// |   symb_timer_done     tick delayed by one cycle                            |
// |   n, n0               symbol counter and its link-up snapshot              |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tx_frame_sequencer_symb_timer
  import tx_seq_pkg::*;
#(
  parameter int unsigned SYMB_DIV = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enc_ready,
  input  logic        capture_n0,
  output logic        tick,
  output logic        symb_timer_done,
  output logic [31:0] n,
  output logic [31:0] n0
);

  // A one-bit divider is kept even for SYMB_DIV=1; it then stays at zero.
  localparam int unsigned          c_div_w    = (SYMB_DIV > 1) ? $clog2(SYMB_DIV) : 1;
  localparam logic [c_div_w-1:0]   c_div_last = c_div_w'(SYMB_DIV - 1);

  logic [c_div_w-1:0] div_q, div_d;
  logic               done_q, done_d;
  logic [31:0]        n_q, n_d;
  logic [31:0]        n0_q, n0_d;

  always_comb begin
    tick   = enc_ready && (div_q == c_div_last);
    div_d  = div_q;
    if (enc_ready) begin
      div_d = tick ? '0 : div_q + c_div_w'(1);
    end
    done_d = tick;
    // Natural 32-bit wrap from all-ones back to zero.
    n_d    = tick ? n_q + 32'd1 : n_q;
    n0_d   = capture_n0 ? n_q : n0_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_q  <= '0;
      done_q <= 1'b0;
      n_q    <= '0;
      n0_q   <= '0;
    end else begin
      div_q  <= div_d;
      done_q <= done_d;
      n_q    <= n_d;
      n0_q   <= n0_d;
    end
  end

  assign symb_timer_done = done_q;
  assign n               = n_q;
  assign n0              = n0_q;

endmodule
`default_nettype wire

// File: rtl/tx_frame_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tx_frame_sequencer                                           |
// | Description : Frame-level scheduler in front of the transmit encoder.      |
// |               Paces MAC bytes onto symbol ticks, enforces the inter-frame  |
// |               gap and maximum frame length, handles underrun and link      |
// |               loss, and never resends a partially transmitted frame.       |
// |   clock, reset          clock / async active-low reset                     |
// |   link_enable           management enable                                  |
// |   loc_rcvr_status       local receiver OK                                  |
// |   mac                   MAC byte stream (slave side)                       |
// |   enc_ready             encoder ready (tx_symb_vector_ready)               |
// |   symb_timer_done       one-cycle symbol strobe                            |
// |   n, n0                 symbol counter / value captured at link-up         |
// |   tx_mode               1 = send normal, 0 = send zeros                    |
// |   tx_enable, tx_error, txd   encoder data path (registered)                |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tx_frame_sequencer
  import tx_seq_pkg::*;
#(
  parameter int unsigned SYMB_DIV  = 1,
  parameter int unsigned MIN_IFG   = c_min_ifg_dflt,
  parameter int unsigned MAX_FRAME = c_max_frame_dflt  // must be below 2048
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  link_enable,
  input  logic                  loc_rcvr_status,
  tx_frame_sequencer_if.slave   mac,
  input  logic                  enc_ready,
  output logic                  symb_timer_done,
  output logic [31:0]           n,
  output logic [31:0]           n0,
  output logic                  tx_mode,
  output logic                  tx_enable,
  output logic                  tx_error,
  output logic [7:0]            txd
);

  localparam logic [15:0] c_gap_init = 16'(MIN_IFG);
  localparam byte_cnt_t   c_max_cnt  = byte_cnt_t'(MAX_FRAME);

  tx_state_e   state_q, state_d;
  logic [15:0] gap_q, gap_d;
  byte_cnt_t   cnt_q, cnt_d;
  logic        pend_q, pend_d;
  logic        tx_mode_q, tx_mode_d;
  logic        tx_enable_q, tx_enable_d;
  logic        tx_error_q, tx_error_d;
  logic [7:0]  txd_q, txd_d;

  logic        w_tick;
  logic        w_link_ok;
  logic        w_capture;
  logic        w_in_ready;
  byte_cnt_t   w_cnt_next;
  gmii_byte_t  w_byte;

  tx_frame_sequencer_symb_timer #(
    .SYMB_DIV (SYMB_DIV)
  ) u_symb_timer (
    .clock           (clock),
    .reset           (reset),
    .enc_ready       (enc_ready),
    .capture_n0      (w_capture),
    .tick            (w_tick),
    .symb_timer_done (symb_timer_done),
    .n               (n),
    .n0              (n0)
  );

  always_comb begin
    w_link_ok   = link_enable && loc_rcvr_status;
    w_byte      = '{data: mac.in_data, last: mac.in_last, error: mac.in_error};
    state_d     = state_q;
    gap_d       = gap_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    tx_enable_d = tx_enable_q;
    tx_error_d  = tx_error_q;
    txd_d       = txd_q;
    w_capture   = 1'b0;
    w_in_ready  = 1'b0;
    w_cnt_next  = '0;

    if ((state_q != ST_DISABLED) && !w_link_ok) begin
      // Link loss overrides everything, including a coincident tick.
      state_d     = ST_DISABLED;
      tx_enable_d = 1'b0;
      tx_error_d  = 1'b0;
      if ((state_q == ST_DATA) || (state_q == ST_DRAIN)) begin
        pend_d = 1'b1;
      end
    end else begin
      // Each new symbol is idle unless a byte or error symbol replaces it,
      // so encoder outputs only ever change right after a tick.
      if (w_tick) begin
        tx_enable_d = 1'b0;
        tx_error_d  = 1'b0;
        txd_d       = '0;
      end

      unique case (state_q)
        ST_DISABLED: begin
          if (w_link_ok) begin
            w_capture = 1'b1;
            if (pend_q) begin
              // Finish discarding the frame that was cut by the link drop.
              state_d = ST_DRAIN;
              pend_d  = 1'b0;
            end else begin
              state_d = ST_IFG;
              gap_d   = c_gap_init;
            end
          end
        end

        ST_IFG: begin
          if (gap_q == 16'd0) begin
            state_d = ST_IDLE;
          end else if (w_tick) begin
            gap_d = gap_q - 16'd1;
            if (gap_q == 16'd1) begin
              state_d = ST_IDLE;
            end
          end
        end

        ST_IDLE, ST_DATA: begin
          w_in_ready = w_tick;
          if (w_tick && mac.in_valid) begin
            w_cnt_next  = (state_q == ST_IDLE) ? byte_cnt_t'(1) : sat_inc(cnt_q);
            cnt_d       = w_cnt_next;
            txd_d       = w_byte.data;
            tx_enable_d = 1'b1;
            tx_error_d  = w_byte.error;
            if (w_byte.last) begin
              state_d = ST_IFG;
              gap_d   = c_gap_init;
            end else if (w_cnt_next >= c_max_cnt) begin
              // Oversize frame: poison this symbol and discard the rest.
              tx_error_d = 1'b1;
              state_d    = ST_DRAIN;
            end else begin
              state_d = ST_DATA;
            end
          end else if (w_tick && (state_q == ST_DATA)) begin
            // Underrun: one error symbol, then discard the rest of the frame.
            tx_enable_d = 1'b1;
            tx_error_d  = 1'b1;
            txd_d       = '0;
            state_d     = ST_DRAIN;
          end
        end

        ST_DRAIN: begin
          // Discard at clock rate, independent of the symbol timer.
          w_in_ready = mac.in_valid;
          if (mac.in_valid && w_byte.last) begin
            state_d = ST_IFG;
            gap_d   = c_gap_init;
          end
        end

        default: begin
          state_d = ST_DISABLED;
        end
      endcase
    end

    tx_mode_d = (state_d != ST_DISABLED);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_DISABLED;
      gap_q       <= '0;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      tx_mode_q   <= 1'b0;
      tx_enable_q <= 1'b0;
      tx_error_q  <= 1'b0;
      txd_q       <= '0;
    end else begin
      state_q     <= state_d;
      gap_q       <= gap_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      tx_mode_q   <= tx_mode_d;
      tx_enable_q <= tx_enable_d;
      tx_error_q  <= tx_error_d;
      txd_q       <= txd_d;
    end
  end

  assign mac.in_ready = w_in_ready;
  assign tx_mode      = tx_mode_q;
  assign tx_enable    = tx_enable_q;
  assign tx_error     = tx_error_q;
  assign txd          = txd_q;

endmodule
`default_nettype wire

// File: tb/tb_tx_frame_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_tx_frame_sequencer                                        |
// | Description : Directed self-checking bench. Main instance runs with        |
// |               SYMB_DIV=1, MIN_IFG=12, MAX_FRAME=4; a second instance with  |
// |               SYMB_DIV=3 exercises the symbol divider.                     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_tx_frame_sequencer;

  logic        clock = 1'b0;
  logic        reset, reset2;
  logic        link_enable, loc_rcvr_status;
  logic        enc_ready, enc_ready2;
  logic        symb_timer_done, tx_mode, tx_enable, tx_error;
  logic [31:0] n, n0;
  logic [7:0]  txd;
  logic        symb_timer_done2, tx_mode2, tx_enable2, tx_error2;
  logic [31:0] n2, n02;
  logic [7:0]  txd2;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  tx_frame_sequencer_if mac();
  tx_frame_sequencer_if mac2();

  tx_frame_sequencer #(.SYMB_DIV(1), .MIN_IFG(12), .MAX_FRAME(4)) dut (
    .clock(clock), .reset(reset), .link_enable(link_enable),
    .loc_rcvr_status(loc_rcvr_status), .mac(mac), .enc_ready(enc_ready),
    .symb_timer_done(symb_timer_done), .n(n), .n0(n0), .tx_mode(tx_mode),
    .tx_enable(tx_enable), .tx_error(tx_error), .txd(txd)
  );

  tx_frame_sequencer #(.SYMB_DIV(3), .MIN_IFG(12), .MAX_FRAME(1522)) dut_div3 (
    .clock(clock), .reset(reset2), .link_enable(1'b0),
    .loc_rcvr_status(1'b0), .mac(mac2), .enc_ready(enc_ready2),
    .symb_timer_done(symb_timer_done2), .n(n2), .n0(n02), .tx_mode(tx_mode2),
    .tx_enable(tx_enable2), .tx_error(tx_error2), .txd(txd2)
  );

  // Counts consecutive sample points with in_ready low, starting at the
  // current one; returns 40 if in_ready never rises.
  task automatic count_gap(output int g);
    g = 0;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (mac.in_ready !== 1'b0) break;
      g++;
      @(negedge clock);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic l, input logic e);
    mac.in_valid = v; mac.in_data = d; mac.in_last = l; mac.in_error = e;
  endtask

  task automatic test_reset;
    reset = 1'b0; reset2 = 1'b0; link_enable = 1'b0; loc_rcvr_status = 1'b0;
    enc_ready = 1'b1; enc_ready2 = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    mac2.in_valid = 1'b0; mac2.in_data = 8'h00; mac2.in_last = 1'b0; mac2.in_error = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if ({tx_enable, tx_error, tx_mode, symb_timer_done, mac.in_ready, txd} !== 13'd0) begin
      errors++;
      $display("FAIL reset_outputs got en=%b err=%b mode=%b done=%b rdy=%b txd=%h want all 0",
               tx_enable, tx_error, tx_mode, symb_timer_done, mac.in_ready, txd);
    end
    checks++;
    if (n !== 32'd0 || n0 !== 32'd0) begin
      errors++; $display("FAIL reset_counters got n=%0d n0=%0d want 0 0", n, n0);
    end
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (n !== 32'd1 || symb_timer_done !== 1'b1) begin
      errors++; $display("FAIL release_first_tick got n=%0d done=%b want 1 1", n, symb_timer_done);
    end
    @(negedge clock);
    checks++;
    if (n !== 32'd2) begin
      errors++; $display("FAIL release_count got n=%0d want 2", n);
    end
  endtask

  task automatic test_bringup;
    int g;
    for (int k = 0; k < 100 && n !== 32'd37; k++) @(negedge clock);
    checks++;
    if (n !== 32'd37) begin
      errors++; $display("FAIL bringup_wait got n=%0d want 37", n);
    end
    link_enable = 1'b1; loc_rcvr_status = 1'b1;
    @(negedge clock);
    checks++;
    if (n0 !== 32'd37) begin
      errors++; $display("FAIL bringup_n0 got %0d want 37", n0);
    end
    checks++;
    if (tx_mode !== 1'b1 || tx_enable !== 1'b0) begin
      errors++; $display("FAIL bringup_mode got mode=%b en=%b want 1 0", tx_mode, tx_enable);
    end
    count_gap(g);
    checks++;
    if (g != 12) begin
      errors++; $display("FAIL bringup_ifg got %0d gap cycles want 12", g);
    end
  endtask

  task automatic test_frame;
    int g;
    checks++;
    if (tx_enable !== 1'b0) begin
      errors++; $display("FAIL frame_pre_idle got en=%b want 0", tx_enable);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'(i), (i == 3), 1'b0);
      @(negedge clock);
      checks++;
      if (tx_enable !== 1'b1 || tx_error !== 1'b0 || txd !== 8'(i)) begin
        errors++;
        $display("FAIL frame_byte%0d got en=%b err=%b txd=%h want 1 0 %h", i, tx_enable, tx_error, txd, 8'(i));
      end
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clock);
    checks++;
    if (tx_enable !== 1'b0) begin
      errors++; $display("FAIL frame_end got en=%b want 0", tx_enable);
    end
    // One IFG cycle already elapsed while the last byte was on txd.
    count_gap(g);
    checks++;
    if (g != 11) begin
      errors++; $display("FAIL frame_ifg got %0d remaining gap cycles want 11", g);
    end
  endtask

  task automatic test_backpressure;
    int g;
    logic [31:0] nsnap;
    drive(1'b1, 8'h00, 1'b0, 1'b0);
    @(negedge clock);
    drive(1'b1, 8'h01, 1'b0, 1'b0);
    @(negedge clock);
    checks++;
    if (txd !== 8'h01 || tx_enable !== 1'b1) begin
      errors++; $display("FAIL bp_byte1 got txd=%h en=%b want 01 1", txd, tx_enable);
    end
    enc_ready = 1'b0;
    drive(1'b1, 8'h02, 1'b0, 1'b0);
    nsnap = n;
    #1;
    checks++;
    if (mac.in_ready !== 1'b0) begin
      errors++; $display("FAIL bp_ready_low got %b want 0", mac.in_ready);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      checks++;
      if (n !== nsnap || txd !== 8'h01 || symb_timer_done !== 1'b0 || tx_enable !== 1'b1 || mac.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_frozen%0d got n=%0d txd=%h done=%b en=%b rdy=%b want n=%0d txd=01 done=0 en=1 rdy=0",
                 k, n, txd, symb_timer_done, tx_enable, mac.in_ready, nsnap);
      end
    end
    enc_ready = 1'b1;
    @(negedge clock);
    checks++;
    if (txd !== 8'h02 || symb_timer_done !== 1'b1 || n !== nsnap + 32'd1) begin
      errors++;
      $display("FAIL bp_resume got txd=%h done=%b n=%0d want 02 1 %0d", txd, symb_timer_done, n, nsnap + 32'd1);
    end
    drive(1'b1, 8'h03, 1'b1, 1'b0);
    @(negedge clock);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    count_gap(g);
    checks++;
    if (g != 12) begin
      errors++; $display("FAIL bp_ifg got %0d want 12", g);
    end
  endtask

  task automatic test_underrun;
    int g;
    drive(1'b1, 8'h00, 1'b0, 1'b0);
    @(negedge clock);
    drive(1'b1, 8'h01, 1'b0, 1'b0);
    @(negedge clock);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clock);
    checks++;
    if (tx_enable !== 1'b1 || tx_error !== 1'b1 || txd !== 8'h00) begin
      errors++; $display("FAIL underrun_symbol got en=%b err=%b txd=%h want 1 1 00", tx_enable, tx_error, txd);
    end
    drive(1'b1, 8'h02, 1'b0, 1'b0);
    #1;
    checks++;
    if (mac.in_ready !== 1'b1) begin
      errors++; $display("FAIL underrun_drain_ready got %b want 1", mac.in_ready);
    end
    @(negedge clock);
    checks++;
    if (tx_enable !== 1'b0 || tx_error !== 1'b0) begin
      errors++; $display("FAIL underrun_one_symbol got en=%b err=%b want 0 0", tx_enable, tx_error);
    end
    drive(1'b1, 8'h03, 1'b1, 1'b0);
    @(negedge clock);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    count_gap(g);
    checks++;
    if (g != 12) begin
      errors++; $display("FAIL underrun_ifg got %0d want 12", g);
    end
  endtask

  task automatic test_link_loss;
    int g;
    logic [31:0] nsnap;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'(i), 1'b0, 1'b0);
      @(negedge clock);
    end
    checks++;
    if (txd !== 8'h02 || tx_enable !== 1'b1) begin
      errors++; $display("FAIL link_byte2 got txd=%h en=%b want 02 1", txd, tx_enable);
    end
    loc_rcvr_status = 1'b0;
    drive(1'b1, 8'h03, 1'b0, 1'b0);
    #1;
    checks++;
    if (mac.in_ready !== 1'b0) begin
      errors++; $display("FAIL link_loss_ready got %b want 0", mac.in_ready);
    end
    @(negedge clock);
    checks++;
    if (tx_enable !== 1'b0 || tx_mode !== 1'b0 || tx_error !== 1'b0) begin
      errors++; $display("FAIL link_loss_out got en=%b mode=%b err=%b want 0 0 0", tx_enable, tx_mode, tx_error);
    end
    @(negedge clock);
    loc_rcvr_status = 1'b1;
    nsnap = n;
    @(negedge clock);
    #1;
    checks++;
    if (n0 !== nsnap || tx_mode !== 1'b1 || tx_enable !== 1'b0 || mac.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL link_return got n0=%0d mode=%b en=%b rdy=%b want %0d 1 0 1", n0, tx_mode, tx_enable, mac.in_ready, nsnap);
    end
    @(negedge clock);
    checks++;
    if (tx_enable !== 1'b0) begin
      errors++; $display("FAIL link_drain_quiet got en=%b want 0", tx_enable);
    end
    drive(1'b1, 8'h04, 1'b1, 1'b0);
    @(negedge clock);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (tx_enable !== 1'b0 || tx_mode !== 1'b1) begin
      errors++; $display("FAIL link_drain_end got en=%b mode=%b want 0 1", tx_enable, tx_mode);
    end
    count_gap(g);
    checks++;
    if (g != 12) begin
      errors++; $display("FAIL link_ifg got %0d want 12", g);
    end
  endtask

  task automatic test_max_frame;
    int g;
    logic exp_err;
    for (int k = 1; k <= 6; k++) begin
      drive(1'b1, 8'h10 + 8'(k), (k == 6), (k == 2));
      @(negedge clock);
      exp_err = (k == 2) || (k == 4);
      checks++;
      if (k <= 4) begin
        if (tx_enable !== 1'b1 || txd !== 8'h10 + 8'(k) || tx_error !== exp_err) begin
          errors++;
          $display("FAIL maxf_byte%0d got en=%b txd=%h err=%b want 1 %h %b", k, tx_enable, txd, tx_error, 8'h10 + 8'(k), exp_err);
        end
      end else if (tx_enable !== 1'b0) begin
        errors++; $display("FAIL maxf_drain%0d got en=%b want 0", k, tx_enable);
      end
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    count_gap(g);
    checks++;
    if (g != 12) begin
      errors++; $display("FAIL maxf_ifg got %0d want 12", g);
    end
  endtask

  task automatic test_reset_midframe;
    drive(1'b1, 8'h00, 1'b0, 1'b0);
    @(negedge clock);
    drive(1'b1, 8'h01, 1'b0, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #1;
    checks++;
    if ({tx_enable, tx_error, tx_mode, symb_timer_done, mac.in_ready, txd} !== 13'd0 || n !== 32'd0 || n0 !== 32'd0) begin
      errors++;
      $display("FAIL midreset got en=%b err=%b mode=%b done=%b rdy=%b txd=%h n=%0d n0=%0d want all 0",
               tx_enable, tx_error, tx_mode, symb_timer_done, mac.in_ready, txd, n, n0);
    end
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (n !== 32'd1 || tx_mode !== 1'b1) begin
      errors++; $display("FAIL midreset_release got n=%0d mode=%b want 1 1", n, tx_mode);
    end
    @(negedge clock);
    checks++;
    if (n !== 32'd2) begin
      errors++; $display("FAIL midreset_count got n=%0d want 2", n);
    end
  endtask

  task automatic test_divider;
    int exp_n [7];
    logic exp_done [7];
    exp_n    = '{0, 0, 1, 1, 1, 2, 2};
    exp_done = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    reset2 = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clock);
      checks++;
      if (n2 !== 32'(exp_n[k]) || symb_timer_done2 !== exp_done[k]) begin
        errors++;
        $display("FAIL div3_step%0d got n=%0d done=%b want %0d %b", k + 1, n2, symb_timer_done2, exp_n[k], exp_done[k]);
      end
    end
    enc_ready2 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      checks++;
      if (n2 !== 32'd2 || symb_timer_done2 !== 1'b0) begin
        errors++; $display("FAIL div3_frozen%0d got n=%0d done=%b want 2 0", k, n2, symb_timer_done2);
      end
    end
    enc_ready2 = 1'b1;
    @(negedge clock);
    checks++;
    if (n2 !== 32'd2 || symb_timer_done2 !== 1'b0) begin
      errors++; $display("FAIL div3_resume1 got n=%0d done=%b want 2 0", n2, symb_timer_done2);
    end
    @(negedge clock);
    checks++;
    if (n2 !== 32'd3 || symb_timer_done2 !== 1'b1) begin
      errors++; $display("FAIL div3_resume2 got n=%0d done=%b want 3 1", n2, symb_timer_done2);
    end
  endtask

  initial begin
    test_reset;
    test_bringup;
    test_frame;
    test_backpressure;
    test_underrun;
    test_link_loss;
    test_max_frame;
    test_reset_midframe;
    test_divider;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
